demux4x1_tdm: RTL and testbench
===============================

DEMUX4X1_TDM -- requirements
Module: demux4x1_tdm

Interface
REQ-001 SHALL have parameter: WIDTH, 1, bit width of each time slot.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: din  input  WIDTH  serial slot data stream.
REQ-005 SHALL have port: din_valid  input  1  din carries a slot this cycle.
REQ-006 SHALL have port: sync  input  1  marks current beat as slot 0; qualified by din_valid.
REQ-007 SHALL have port: y0, y1, y2, y3  output  WIDTH each  registered de-multiplexed slot outputs.
REQ-008 SHALL have port: frame_valid  output  1  one-cycle pulse when y0..y3 update.
REQ-009 SHALL have port: slot  output  2  index of the next slot to be written.
REQ-010 SHALL have port: locked  output  1  high in RUN state.
REQ-011 SHALL have port: sync_err  output  1  one-cycle pulse on misaligned sync.

Function
REQ-012 SHALL implement two states, HUNT and RUN; locked = (state == RUN).
REQ-013 HUNT: beats without sync are ignored; a beat with din_valid&sync SHALL write staging[0], set slot=1 and enter RUN.
REQ-014 RUN, din_valid low: no state, slot, staging or output change.
REQ-015 RUN, din_valid high and sync low: SHALL write din to staging[slot], slot = slot+1 mod 4.
REQ-016 RUN, beat written at slot 3: on the same edge, y0..y2 <= staging[0..2], y3 <= din, frame_valid <= 1, slot <= 0; outputs are visible the cycle after the 4th beat (latency 1).
REQ-017 RUN, sync high with din_valid at slot 0: normal slot-0 write, no error.
REQ-018 RUN, sync high with din_valid at slot 1..3: SHALL pulse sync_err, discard partial frame (no frame_valid), write din to staging[0], set slot=1, remain RUN.
REQ-019 RUN, din_valid high at slot 0 without sync: SHALL be accepted as slot 0 (free-running framing).
REQ-020 y0..y3 SHALL hold their last value between frames; frame_valid and sync_err SHALL be low except on the single cycle after their triggering edge.
REQ-021 Consecutive frames at full rate (din_valid every cycle) SHALL produce frame_valid every 4th cycle with no lost beats.
REQ-022 Inputs sampled while din_valid is low SHALL have no effect, including sync.

Reset
REQ-023 rst high at a clock edge SHALL set state=HUNT, slot=0, staging=0, y0..y3=0, frame_valid=0, sync_err=0, locked=0.
REQ-024 rst SHALL take priority over every other input on the same edge, including a 4th beat; a partial frame at reset SHALL be discarded with no frame_valid.
REQ-025 After rst deasserts, the first frame SHALL require a sync beat.

Verification (WIDTH=4)
REQ-026 Reset then 4 valid beats A,B,C,D with sync on A -> next cycle y0..y3 = A,B,C,D, frame_valid = 1 for exactly one cycle, slot = 0, locked = 1.
REQ-027 Beats 1,2,3 without sync after reset -> no output change, locked = 0, slot = 0; then sync beat 5 followed by 6,7,8 -> y = 5,6,7,8.
REQ-028 Locked; beats 1,2 then sync beat 9 followed by A,B,C -> sync_err one-cycle pulse, no frame_valid for 1,2, then y = 9,A,B,C.
REQ-029 Locked; beats 1,_,2,_,_,3,4 (gaps with din_valid=0 and sync=1 during gaps) -> y = 1,2,3,4, no sync_err.
REQ-030 Locked, 8 back-to-back beats 0..7 with sync only on 0 -> frame_valid on cycles 4 and 8, y = 0..3 then 4..7.
REQ-031 rst asserted coincident with 4th beat -> y stay 0, no frame_valid, state HUNT, slot 0.

Source files
------------

// File: rtl/demux4x1_tdm.sv
// demux4x1_tdm -- four-slot time-division de-multiplexer.
//
// A serial stream of WIDTH-bit slots arrives on din, one slot per cycle in
// which din_valid is high. A sync beat marks slot 0. Once locked, every four
// accepted beats are released together on y0..y3 with a one-cycle
// frame_valid pulse. A sync beat arriving at slot 1..3 drops the partial
// frame, pulses sync_err and restarts the frame from that beat.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   din         slot data
//   din_valid   din carries a slot this cycle
//   sync        current beat is slot 0 (only meaningful with din_valid)
//   y0..y3      registered frame outputs, held between frames
//   frame_valid one-cycle pulse when y0..y3 update
//   slot        index of the next slot to be written
//   locked      high while framing is established (RUN)
//   sync_err    one-cycle pulse on a misaligned sync beat
module demux4x1_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state;
  // Slot 3 is never staged: it goes straight to y3 on the closing beat.
  logic [WIDTH-1:0] staging [3];

  assign locked = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= '0;
      for (int unsigned i = 0; i < 3; i++) staging[i] <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      case (state)
        HUNT: begin
          if (din_valid && sync) begin
            staging[0] <= din;
            slot       <= 2'd1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (din_valid) begin
            if (sync && slot != 2'd0) begin
              // Realign: this beat becomes slot 0 of a fresh frame.
              sync_err   <= 1'b1;
              staging[0] <= din;
              slot       <= 2'd1;
            end else begin
              case (slot)
                2'd0: staging[0] <= din;
                2'd1: staging[1] <= din;
                2'd2: staging[2] <= din;
                2'd3: begin
                  y0          <= staging[0];
                  y1          <= staging[1];
                  y2          <= staging[2];
                  y3          <= din;
                  frame_valid <= 1'b1;
                end
                default: ;
              endcase
              // 3 + 1 wraps to 0, starting the next frame.
              slot <= slot + 2'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_demux4x1_tdm.sv
module tb_demux4x1_tdm;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  int totalCnt = 0;
  int badCnt   = 0;
  bit checkEn  = 1'b0;

  demux4x1_tdm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: the current partial frame is a queue of beats.
  bit           mLocked = 1'b0;
  logic [W-1:0] mBeats[$];
  logic [W-1:0] mY[4] = '{default: '0};
  bit           mFv = 1'b0;
  bit           mSe = 1'b0;

  always @(posedge clk) begin
    mFv = 1'b0;
    mSe = 1'b0;
    if (rst) begin
      mLocked = 1'b0;
      mBeats.delete();
      for (int i = 0; i < 4; i++) mY[i] = '0;
    end else if (din_valid) begin
      if (!mLocked) begin
        if (sync) begin
          mLocked = 1'b1;
          mBeats.delete();
          mBeats.push_back(din);
        end
      end else if (sync && mBeats.size() != 0) begin
        mSe = 1'b1;
        mBeats.delete();
        mBeats.push_back(din);
      end else begin
        mBeats.push_back(din);
        if (mBeats.size() == 4) begin
          for (int i = 0; i < 4; i++) mY[i] = mBeats[i];
          mFv = 1'b1;
          mBeats.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      chk("model_y0", 32'(y0), 32'(mY[0]));
      chk("model_y1", 32'(y1), 32'(mY[1]));
      chk("model_y2", 32'(y2), 32'(mY[2]));
      chk("model_y3", 32'(y3), 32'(mY[3]));
      chk("model_frame_valid", 32'(frame_valid), 32'(mFv));
      chk("model_sync_err", 32'(sync_err), 32'(mSe));
      chk("model_slot", 32'(slot), 32'(mBeats.size()));
      chk("model_locked", 32'(locked), 32'(mLocked));
    end
  end

  // Apply one cycle of inputs; returns just after the edge that sampled them.
  task automatic drive(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst = r; din_valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chkY(input string name, input logic [15:0] exp);
    chk(name, {16'h0, y0, y1, y2, y3}, {16'h0, exp});
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;
    drive(1, 0, 0, 0);
    checkEn = 1'b1;
    drive(1, 0, 0, 0);
    chkY("reset_y", 16'h0000);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_slot", 32'(slot), 0);
    chk("reset_fv", 32'(frame_valid), 0);

    // Sync frame A,B,C,D straight after reset.
    drive(0, 1, 1, 4'hA);
    drive(0, 1, 0, 4'hB);
    drive(0, 1, 0, 4'hC);
    drive(0, 1, 0, 4'hD);
    chkY("abcd_y", 16'hABCD);
    chk("abcd_fv", 32'(frame_valid), 1);
    chk("abcd_slot", 32'(slot), 0);
    chk("abcd_locked", 32'(locked), 1);
    drive(0, 0, 0, 0);
    chk("abcd_fv_one_cycle", 32'(frame_valid), 0);
    chkY("abcd_hold", 16'hABCD);

    // Beats without sync after reset are ignored.
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 4'h1);
    drive(0, 1, 0, 4'h2);
    drive(0, 1, 0, 4'h3);
    chkY("hunt_y", 16'h0000);
    chk("hunt_locked", 32'(locked), 0);
    chk("hunt_slot", 32'(slot), 0);
    drive(0, 1, 1, 4'h5);
    drive(0, 1, 0, 4'h6);
    drive(0, 1, 0, 4'h7);
    drive(0, 1, 0, 4'h8);
    chkY("hunt_then_sync_y", 16'h5678);

    // Misaligned sync restarts the frame.
    drive(0, 1, 0, 4'h1);
    drive(0, 1, 0, 4'h2);
    drive(0, 1, 1, 4'h9);
    chk("misalign_err", 32'(sync_err), 1);
    chk("misalign_fv", 32'(frame_valid), 0);
    chk("misalign_slot", 32'(slot), 1);
    drive(0, 1, 0, 4'hA);
    chk("misalign_err_pulse", 32'(sync_err), 0);
    drive(0, 1, 0, 4'hB);
    drive(0, 1, 0, 4'hC);
    chkY("misalign_y", 16'h9ABC);
    chk("misalign_fv_end", 32'(frame_valid), 1);

    // Gaps with sync high while din_valid is low.
    drive(0, 1, 0, 4'h1);
    drive(0, 0, 1, 4'hF);
    drive(0, 1, 0, 4'h2);
    drive(0, 0, 1, 4'hE);
    drive(0, 0, 1, 4'hD);
    drive(0, 1, 0, 4'h3);
    drive(0, 1, 0, 4'h4);
    chkY("gaps_y", 16'h1234);
    chk("gaps_err", 32'(sync_err), 0);

    // Back-to-back frames, sync only on the first beat.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, (i == 0), W'(i));
      if (i == 3) begin
        chkY("b2b_first_y", 16'h0123);
        chk("b2b_first_fv", 32'(frame_valid), 1);
      end
      if (i == 4) chk("b2b_mid_fv", 32'(frame_valid), 0);
    end
    chkY("b2b_second_y", 16'h4567);
    chk("b2b_second_fv", 32'(frame_valid), 1);

    // Reset coincident with the 4th beat.
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 4'h1);
    drive(0, 1, 0, 4'h2);
    drive(0, 1, 0, 4'h3);
    drive(1, 1, 0, 4'h4);
    chkY("rst4_y", 16'h0000);
    chk("rst4_fv", 32'(frame_valid), 0);
    chk("rst4_locked", 32'(locked), 0);
    chk("rst4_slot", 32'(slot), 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
